// File: rtl/sqr_pkg.sv
// sqr_pkg: state encoding and result-width helper for the sequential squarer.
package sqr_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_e;
    function automatic int sq_w(input int zsize);
        return 2 * zsize;
    endfunction
endpackage

// File: rtl/sqr_seq_if.sv
// sqr_seq_if: operand/result valid-ready streams of sqr_seq.
// SQR_SEQ_REM_EN adds the sqrt remainder input and the illegal-remainder flag.
interface sqr_seq_if
    import sqr_pkg::*;
#(
    parameter int ZSIZE = 4
) ();
    logic                   in_valid;
    logic                   in_ready;
    logic [ZSIZE-1:0]       in_z;
    logic                   out_valid;
    logic                   out_ready;
    logic [sq_w(ZSIZE)-1:0] out_sq;
    logic                   busy;
`ifdef SQR_SEQ_REM_EN
    logic [ZSIZE:0]         in_rem;
    logic                   out_err;
    modport master (output in_valid, in_z, in_rem, out_ready,
                    input in_ready, out_valid, out_sq, out_err, busy);
    modport slave (input in_valid, in_z, in_rem, out_ready,
                   output in_ready, out_valid, out_sq, out_err, busy);
`else
    modport master (output in_valid, in_z, out_ready,
                    input in_ready, out_valid, out_sq, busy);
    modport slave (input in_valid, in_z, out_ready,
                   output in_ready, out_valid, out_sq, busy);
`endif
endinterface

// File: rtl/sqr_step.sv
// sqr_step: one MSB-first squaring step; adding root bit i grows v^2 by (v<<(i+1)) + 4^i.
module sqr_step
    import sqr_pkg::*;
#(
    parameter int ZSIZE = 4
) (
    input  logic [sq_w(ZSIZE)-1:0]   acc_i,
    input  logic [ZSIZE-1:0]         v_i,
    input  logic [$clog2(ZSIZE)-1:0] i_i,
    input  logic                     zbit_i,
    output logic [sq_w(ZSIZE)-1:0]   acc_next_o,
    output logic [ZSIZE-1:0]         v_next_o
);
    localparam int W = sq_w(ZSIZE);
    logic [W-1:0] term;
    // v only holds bits above i, so the two parts never overlap and OR equals add
    assign term = ((W'(v_i) << i_i) << 1) | (W'(1) << {i_i, 1'b0});
    assign acc_next_o = zbit_i ? acc_i + term : acc_i;
    assign v_next_o = zbit_i ? v_i | (ZSIZE'(1) << i_i) : v_i;
endmodule

// File: rtl/sqr_seq.sv
// sqr_seq: sequential squarer, one root bit per clock, valid/ready on both sides.
// SQR_SEQ_REM_EN seeds the accumulator with the sqrt remainder and flags illegal ones.
module sqr_seq
    import sqr_pkg::*;
#(
    parameter int ZSIZE = 4
) (
    input logic      clk,
    input logic      rst_n,
    sqr_seq_if.slave bus
);
    localparam int W  = sq_w(ZSIZE);
    localparam int CW = $clog2(ZSIZE);
    state_e           state_q;
    logic [ZSIZE-1:0] z_q, v_q, v_d;
    logic [W-1:0]     acc_q, acc_d, acc_init, out_sq_q;
    logic [CW-1:0]    cnt_q;
    logic             in_ready_q, out_valid_q, accept, last;
    assign accept = state_q == IDLE && bus.in_valid && in_ready_q;
    assign last = state_q == CALC && cnt_q == '0;
    sqr_step #(.ZSIZE(ZSIZE)) u_step (
        .acc_i(acc_q), .v_i(v_q), .i_i(cnt_q), .zbit_i(z_q[cnt_q]),
        .acc_next_o(acc_d), .v_next_o(v_d)
    );
`ifdef SQR_SEQ_REM_EN
    logic err_q, out_err_q;
    assign acc_init = W'(bus.in_rem);
    assign bus.out_err = out_err_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
            out_err_q <= 1'b0;
        end else begin
            if (accept) err_q <= bus.in_rem > {bus.in_z, 1'b0};
            if (last) out_err_q <= err_q;
        end
    end
`else
    assign acc_init = '0;
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            z_q <= '0;
            v_q <= '0;
            acc_q <= '0;
            cnt_q <= '0;
            out_sq_q <= '0;
            in_ready_q <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    in_ready_q <= !accept;
                    if (accept) begin
                        z_q <= bus.in_z;
                        acc_q <= acc_init;
                        v_q <= '0;
                        cnt_q <= CW'(ZSIZE - 1);
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    acc_q <= acc_d;
                    v_q <= v_d;
                    cnt_q <= cnt_q - 1'b1;
                    if (last) begin
                        out_sq_q <= acc_d;
                        out_valid_q <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign bus.in_ready = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sq = out_sq_q;
    assign bus.busy = state_q != IDLE;
endmodule

// File: tb/tb_sqr_seq.sv
// tb_sqr_seq: table-driven and hand-sequenced checks of sqr_seq at ZSIZE=4 plus a full ZSIZE=8 sweep.
module tb_sqr_seq;
    import sqr_pkg::*;
    typedef struct {
        logic [3:0] z;
        logic [4:0] rem;
        int         hold;
        logic [7:0] sq;
        logic       err;
    } vec_t;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int total = 0;
    int bad = 0;
    logic [7:0] qa[$];
    logic [15:0] qb[$];
    vec_t vt[$];
    sqr_seq_if #(.ZSIZE(4)) ia ();
    sqr_seq_if #(.ZSIZE(8)) ib ();
    sqr_seq #(.ZSIZE(4)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia));
    sqr_seq #(.ZSIZE(8)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib));
    always #5 clk = ~clk;

    task automatic chk(input string n, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", n, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic xact_a(input vec_t v);
        int c = 0;
        int rdy = 0;
        logic [7:0] e;
        ia.in_z = v.z;
`ifdef SQR_SEQ_REM_EN
        ia.in_rem = v.rem;
`endif
        ia.in_valid = 1'b1;
        while (!ia.in_ready && c < 40) begin tick(); c++; end
        chk("a_accept_wait", c < 40, 1);
        qa.push_back(v.sq);
        tick();
        ia.in_valid = 1'b0;
        chk("a_busy_calc", ia.busy, 1);
        c = 0;
        while (!ia.out_valid && c < 40) begin rdy += ia.in_ready; tick(); c++; end
        chk("a_latency", c, 4);
        chk("a_rdy_in_calc", rdy, 0);
        e = qa.pop_front();
        chk("a_sq", ia.out_sq, e);
`ifdef SQR_SEQ_REM_EN
        chk("a_err", ia.out_err, v.err);
`endif
        for (int h = 0; h < v.hold; h++) begin
            ia.in_valid = 1'b1;
            ia.in_z = ~v.z;
            tick();
            chk("a_hold_valid", ia.out_valid, 1);
            chk("a_hold_sq", ia.out_sq, e);
            chk("a_hold_rdy", ia.in_ready, 0);
        end
        ia.in_valid = 1'b0;
        ia.out_ready = 1'b1;
        tick();
        ia.out_ready = 1'b0;
        chk("a_hs_valid", ia.out_valid, 0);
        chk("a_hs_rdy", ia.in_ready, 1);
        chk("a_hs_busy", ia.busy, 0);
        chk("a_sq_kept", ia.out_sq, e);
    endtask

    initial begin
        ia.in_valid = 1'b1;
        ia.in_z = 4'd3;
        ia.out_ready = 1'b0;
        ib.in_valid = 1'b0;
        ib.in_z = '0;
        ib.out_ready = 1'b0;
`ifdef SQR_SEQ_REM_EN
        ia.in_rem = '0;
        ib.in_rem = '0;
`endif
        vt.push_back('{4'd13, 5'd0, 0, 8'd169, 1'b0});
        vt.push_back('{4'd9, 5'd0, 3, 8'd81, 1'b0});
        vt.push_back('{4'd15, 5'd0, 0, 8'd225, 1'b0});
        vt.push_back('{4'd1, 5'd0, 1, 8'd1, 1'b0});
        vt.push_back('{4'd2, 5'd0, 0, 8'd4, 1'b0});
`ifdef SQR_SEQ_REM_EN
        vt.push_back('{4'd11, 5'd4, 0, 8'd125, 1'b0});
        vt.push_back('{4'd11, 5'd23, 0, 8'd144, 1'b1});
        vt.push_back('{4'd15, 5'd30, 0, 8'd255, 1'b0});
`endif
        #1 rst_n = 1'b0;
        #1;
        chk("rst_in_ready", ia.in_ready, 0);
        chk("rst_out_valid", ia.out_valid, 0);
        chk("rst_out_sq", ia.out_sq, 0);
        chk("rst_busy", ia.busy, 0);
        #10;
        chk("rst_ignores_valid", ia.busy, 0);
        ia.in_valid = 1'b0;
        rst_n = 1'b1;
        #1 chk("rel_rdy_low", ia.in_ready, 0);
        tick();
        chk("rel_rdy_high", ia.in_ready, 1);
        chk("rel_busy", ia.busy, 0);
        foreach (vt[k]) xact_a(vt[k]);
`ifdef SQR_SEQ_REM_EN
        ia.in_rem = '0;
`endif
        ia.in_z = 4'd7;
        ia.in_valid = 1'b1;
        tick();
        ia.in_valid = 1'b0;
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("abort_rdy", ia.in_ready, 0);
        chk("abort_valid", ia.out_valid, 0);
        chk("abort_sq", ia.out_sq, 0);
        chk("abort_busy", ia.busy, 0);
        #2 rst_n = 1'b1;
        tick();
        chk("abort_rdy_back", ia.in_ready, 1);
        xact_a('{4'd5, 5'd0, 0, 8'd25, 1'b0});
        ia.out_ready = 1'b1;
        ia.in_valid = 1'b1;
        ia.in_z = 4'd15;
        qa.push_back(8'd225);
        tick();
        ia.in_z = 4'd0;
        repeat (3) tick();
        chk("b2b_early_valid", ia.out_valid, 0);
        tick();
        chk("b2b_valid1", ia.out_valid, 1);
        chk("b2b_sq1", ia.out_sq, qa.pop_front());
        tick();
        chk("b2b_gap_busy", ia.busy, 0);
        chk("b2b_gap_rdy", ia.in_ready, 1);
        qa.push_back(8'd0);
        tick();
        ia.in_valid = 1'b0;
        chk("b2b_busy2", ia.busy, 1);
        repeat (4) tick();
        chk("b2b_valid2", ia.out_valid, 1);
        chk("b2b_sq2", ia.out_sq, qa.pop_front());
        tick();
        ia.out_ready = 1'b0;
        chk("b2b_done", ia.out_valid, 0);
        ib.out_ready = 1'b1;
        for (int z = 0; z < 256; z++) begin
            int c;
            c = 0;
            ib.in_z = 8'(z);
            ib.in_valid = 1'b1;
            while (!ib.in_ready && c < 40) begin tick(); c++; end
            qb.push_back(16'(z * z));
            tick();
            ib.in_valid = 1'b0;
            c = 0;
            while (!ib.out_valid && c < 40) begin tick(); c++; end
            chk($sformatf("b_sq_z%0d", z), ib.out_sq, qb.pop_front());
            tick();
        end
        chk("queues_empty", qa.size() + qb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
